mem_burst_ctrl: RTL and testbench

Command-driven burst master for the single-port 32-bit sequential memory (valid/ready, wrbar-encoded). Accepts one command at a time (op, start address, length), streams write words in from a source or read words out to a sink, and runs the per-word memory handshake, wrapping the address modulo DEPTH. Sits directly upstream of the memory, replacing hand-driven address/valid sequencing.

---
 rtl/mem_burst_pkg.sv | 19 +
 rtl/mbc_addr_gen.sv | 38 +++
 rtl/mem_burst_ctrl.sv | 152 +++++++++++++++
 tb/tb_mem_burst_ctrl.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_burst_pkg.sv
// Shared types and defaults for the mem_burst_ctrl burst master.
package mem_burst_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WDATA  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_ADDR    = 8;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_TIMEOUT = 64;

endpackage

// File: rtl/mbc_addr_gen.sv
// Burst address/length tracker: loads start and length, steps per completed beat,
// wraps the address modulo DEPTH and flags the final beat.
module mbc_addr_gen
  import mem_burst_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int ADDR  = DEF_ADDR
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_load,
  input  logic [ADDR-1:0] i_start,
  input  logic [ADDR:0]   i_len,
  input  logic            i_step,
  output logic [ADDR-1:0] o_addr,
  output logic            o_last
);

  logic [ADDR-1:0] r_addr;
  logic [ADDR:0]   r_remaining;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
    end else if (i_load) begin
      r_addr      <= i_start;
      r_remaining <= i_len;
    end else if (i_step) begin
      r_addr      <= (r_addr == ADDR'(DEPTH - 1)) ? '0 : r_addr + 1'b1;
      r_remaining <= r_remaining - 1'b1;
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_remaining == (ADDR+1)'(1));

endmodule

// File: rtl/mem_burst_ctrl.sv
// Command-driven burst master for a valid/ready sequential memory.
// Define MBC_TIMEOUT_EN to abort a beat that waits TIMEOUT cycles for mem_ready.
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int ADDR    = DEF_ADDR,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic             i_cmd_wr,
  input  logic [ADDR-1:0]  i_cmd_addr,
  input  logic [ADDR:0]    i_cmd_len,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_wr_valid,
  output logic             o_wr_ready,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic             o_done,
  output logic             o_err,
  output logic [ADDR-1:0]  o_mem_addr,
  output logic [WIDTH-1:0] o_mem_wdata,
  output logic             o_mem_wrbar,
  output logic             o_mem_valid,
  input  logic             i_mem_ready,
  input  logic [WIDTH-1:0] i_mem_rdata
);

  state_t          r_state;
  state_t          w_nextState;
  logic            r_op;
  logic [WIDTH-1:0] r_memWdata;
  logic [WIDTH-1:0] r_rdData;
  logic            r_memValid;
  logic            r_rdValid;
  logic            r_done;
  logic            w_cmdReady;
  logic            w_wrReady;
  logic            w_accept;
  logic            w_beat;
  logic            w_last;
  logic            w_abort;
  logic [ADDR-1:0] w_addr;

  assign w_accept = i_cmd_valid && w_cmdReady;
  assign w_beat   = (r_state == ACCESS) && i_mem_ready;

  mbc_addr_gen #(.DEPTH(DEPTH), .ADDR(ADDR)) u_addr_gen (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_accept),
    .i_start (i_cmd_addr),
    .i_len   (i_cmd_len),
    .i_step  (w_beat),
    .o_addr  (w_addr),
    .o_last  (w_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (i_cmd_len == '0)        w_nextState = DONE;
          else if (i_cmd_wr == OP_WR) w_nextState = WDATA;
          else                        w_nextState = ACCESS;
        end
      end
      WDATA:  if (i_wr_valid) w_nextState = ACCESS;
      ACCESS: begin
        if (w_abort)     w_nextState = DONE;
        else if (w_beat) w_nextState = w_last ? DONE : ((r_op == OP_WR) ? WDATA : ACCESS);
      end
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // cmd_ready is masked during reset so no command is taken before state is known.
  always_comb begin
    w_cmdReady = 1'b0;
    w_wrReady  = 1'b0;
    case (r_state)
      IDLE:    w_cmdReady = !i_rst;
      WDATA:   w_wrReady  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_op       <= OP_RD;
      r_memWdata <= '0;
      r_rdData   <= '0;
      r_memValid <= 1'b0;
      r_rdValid  <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_memValid <= (w_nextState == ACCESS);
      r_rdValid  <= w_beat && (r_op == OP_RD);
      r_done     <= (w_nextState == DONE);
      if (w_accept) r_op <= i_cmd_wr;
      if ((r_state == WDATA) && i_wr_valid) r_memWdata <= i_wr_data;
      if (w_beat && (r_op == OP_RD)) r_rdData <= i_mem_rdata;
    end
  end

`ifdef MBC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_waitCnt;
  logic          r_err;

  // Any ready in ACCESS completes the beat, so clearing on ready restarts each beat.
  always_ff @(posedge i_clk) begin
    if (i_rst || (r_state != ACCESS) || i_mem_ready) r_waitCnt <= '0;
    else                                            r_waitCnt <= r_waitCnt + 1'b1;
  end

  assign w_abort = (r_state == ACCESS) && !i_mem_ready && (r_waitCnt == TW'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || w_accept) r_err <= 1'b0;
    else if (w_abort)      r_err <= 1'b1;
  end

  assign o_err = r_err;
`else
  assign w_abort = 1'b0;
  assign o_err   = 1'b0;
`endif

  assign o_cmd_ready = w_cmdReady;
  assign o_wr_ready  = w_wrReady;
  assign o_rd_data   = r_rdData;
  assign o_rd_valid  = r_rdValid;
  assign o_done      = r_done;
  assign o_mem_addr  = w_addr;
  assign o_mem_wdata = r_memWdata;
  assign o_mem_wrbar = r_op;
  assign o_mem_valid = r_memValid;

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: memory model, bus monitor and reference array.
// Covers the MBC_TIMEOUT_EN abort path only when that macro is defined.
module tb_mem_burst_ctrl;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 256;
  localparam int ADDR    = 8;
  localparam int TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
  logic [ADDR-1:0] cmd_addr = '0;
  logic [ADDR:0] cmd_len = '0;
  logic [WIDTH-1:0] wr_data = '0;
  logic wr_valid = 1'b0, wr_ready;
  logic [WIDTH-1:0] rd_data;
  logic rd_valid, done, err;
  logic [ADDR-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;
  logic mem_wrbar, mem_valid;
  logic mem_ready = 1'b0;

  int nCompared = 0;
  int nMismatched = 0;

  logic [WIDTH-1:0] memArr [DEPTH];
  logic [WIDTH-1:0] refMem [DEPTH];
  logic [WIDTH-1:0] wrWords [DEPTH];
  int readyMode = 0;
  int cycleCnt = 0;
  int doneCount, doneCycle, validSeen, acceptCycle;
  logic [WIDTH-1:0] rdQ [$];
  int beatAddrQ [$];
  logic beatWrQ [$];

  mem_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_wr(cmd_wr),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_wr_data(wr_data), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .o_rd_data(rd_data), .o_rd_valid(rd_valid), .o_done(done), .o_err(err),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wrbar(mem_wrbar),
    .o_mem_valid(mem_valid), .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] initPattern(input int i);
    return (i < 4) ? WIDTH'(32'h10 + i) : (32'hC0DE_0000 | WIDTH'(i));
  endfunction

  // Memory: ready follows valid one cycle later (mode 0), random stalls (1), stuck low (2).
  assign mem_rdata = memArr[mem_addr];
  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) memArr[i] <= initPattern(i);
    end else if (mem_valid && mem_ready && mem_wrbar) begin
      memArr[mem_addr] <= mem_wdata;
    end
    case (readyMode)
      0:       mem_ready <= mem_valid;
      1:       mem_ready <= mem_valid && ($urandom_range(0, 2) != 0);
      default: mem_ready <= 1'b0;
    endcase
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid) rdQ.push_back(rd_data);
      if (mem_valid) begin
        validSeen++;
        if (mem_ready) begin
          beatAddrQ.push_back(int'(mem_addr));
          beatWrQ.push_back(mem_wrbar);
        end
      end
      if (done) begin
        doneCount++;
        doneCycle = cycleCnt;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic initRef();
    for (int i = 0; i < DEPTH; i++) refMem[i] = initPattern(i);
  endtask

  task automatic clearMon();
    rdQ.delete();
    beatAddrQ.delete();
    beatWrQ.delete();
    doneCount = 0;
    validSeen = 0;
  endtask

  task automatic applyStimulus(input bit wr, input int addr, input int len, input bit poke);
    int idx;
    int waitCnt;
    clearMon();
    waitCnt = 0;
    while (!cmd_ready && waitCnt < 100) begin
      tick();
      waitCnt++;
    end
    cmd_valid = 1'b1;
    cmd_wr    = wr;
    cmd_addr  = ADDR'(addr);
    cmd_len   = (ADDR+1)'(len);
    tick();
    acceptCycle = cycleCnt;
    cmd_valid = 1'b0;
    idx = 0;
    waitCnt = 0;
    while (doneCount == 0 && waitCnt < 3000) begin
      wr_valid = wr && (idx < len) && (readyMode == 0 || $urandom_range(0, 3) != 0);
      wr_data  = wr_valid ? wrWords[idx] : WIDTH'($urandom);
      if (wr_valid && wr_ready) idx++;
      cmd_valid = poke && (waitCnt >= 1) && (waitCnt <= 3);
      if (poke) begin
        cmd_wr  = 1'b1;
        cmd_len = (ADDR+1)'(5);
      end
      tick();
      waitCnt++;
    end
    wr_valid  = 1'b0;
    cmd_valid = 1'b0;
    if (doneCount == 0) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL burst_timeout: no done after %0d cycles, required done pulse", waitCnt);
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    initRef();
    nCompared++;
    if ({cmd_ready, wr_ready, rd_valid, done, err, mem_valid, mem_wrbar} !== 7'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_ctrl: got %b required 0000000", {cmd_ready, wr_ready, rd_valid, done, err, mem_valid, mem_wrbar});
    end
    nCompared++;
    if ({mem_addr, mem_wdata, rd_data} !== '0) begin
      nMismatched++;
      $display("[TB] FAIL reset_data: addr %0h wdata %0h rdata %0h required 0", mem_addr, mem_wdata, rd_data);
    end
    rst = 1'b0;
    tick();
    nCompared++;
    if (cmd_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL reset_release_ready: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_read_basic();
    readyMode = 0;
    applyStimulus(1'b0, 0, 4, 1'b0);
    nCompared++;
    if (rdQ.size() != 4) begin
      nMismatched++;
      $display("[TB] FAIL read_count: got %0d required 4", rdQ.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        nCompared++;
        if (rdQ[i] !== refMem[i]) begin
          nMismatched++;
          $display("[TB] FAIL read_word%0d: got %0h required %0h", i, rdQ[i], refMem[i]);
        end
      end
    end
    nCompared++;
    if (doneCycle - acceptCycle != 5) begin
      nMismatched++;
      $display("[TB] FAIL read_latency: done %0d cycles after accept, required 5", doneCycle - acceptCycle);
    end
    nCompared++;
    if (doneCount != 1) begin
      nMismatched++;
      $display("[TB] FAIL read_done_once: got %0d required 1", doneCount);
    end
  endtask

  task automatic test_write();
    wrWords[0] = 32'hA; wrWords[1] = 32'hB; wrWords[2] = 32'hC;
    readyMode = 0;
    applyStimulus(1'b1, 32, 3, 1'b0);
    for (int i = 0; i < 3; i++) refMem[32 + i] = wrWords[i];
    nCompared++;
    if (beatAddrQ.size() != 3 || beatAddrQ[0] != 32 || beatAddrQ[1] != 33 || beatAddrQ[2] != 34) begin
      nMismatched++;
      $display("[TB] FAIL write_addrs: got %p required 32,33,34", beatAddrQ);
    end
    nCompared++;
    if (beatWrQ.size() != 3 || beatWrQ.sum() with (int'(item)) != 3) begin
      nMismatched++;
      $display("[TB] FAIL write_wrbar: got %p required all 1", beatWrQ);
    end
    for (int i = 32; i < 35; i++) begin
      nCompared++;
      if (memArr[i] !== refMem[i]) begin
        nMismatched++;
        $display("[TB] FAIL write_mem%0d: got %0h required %0h", i, memArr[i], refMem[i]);
      end
    end
    nCompared++;
    if (doneCount != 1) begin
      nMismatched++;
      $display("[TB] FAIL write_done_once: got %0d required 1", doneCount);
    end
    applyStimulus(1'b0, 32, 3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      nCompared++;
      if (i >= rdQ.size() || rdQ[i] !== refMem[32 + i]) begin
        nMismatched++;
        $display("[TB] FAIL readback%0d: got %0h required %0h", i, (i < rdQ.size()) ? rdQ[i] : '0, refMem[32 + i]);
      end
    end
  endtask

  task automatic test_wrap();
    int expAddr [4] = '{254, 255, 0, 1};
    readyMode = 0;
    applyStimulus(1'b0, 254, 4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      nCompared++;
      if (i >= beatAddrQ.size() || beatAddrQ[i] != expAddr[i]) begin
        nMismatched++;
        $display("[TB] FAIL wrap_addr%0d: got %0d required %0d", i, (i < beatAddrQ.size()) ? beatAddrQ[i] : -1, expAddr[i]);
      end
    end
    nCompared++;
    if (doneCount != 1 || beatAddrQ.size() != 4) begin
      nMismatched++;
      $display("[TB] FAIL wrap_end: done %0d beats %0d required 1 and 4", doneCount, beatAddrQ.size());
    end
  endtask

  task automatic test_len_zero_busy();
    readyMode = 0;
    applyStimulus(1'b0, 7, 0, 1'b0);
    nCompared++;
    if (validSeen != 0 || doneCycle != acceptCycle || doneCount != 1) begin
      nMismatched++;
      $display("[TB] FAIL len_zero: valid %0d done_offset %0d done %0d required 0,0,1", validSeen, doneCycle - acceptCycle, doneCount);
    end
    applyStimulus(1'b0, 10, 6, 1'b1);
    nCompared++;
    if (beatAddrQ.size() != 6 || beatWrQ.sum() with (int'(item)) != 0 || doneCount != 1) begin
      nMismatched++;
      $display("[TB] FAIL busy_ignore: beats %0d writes %0d done %0d required 6,0,1", beatAddrQ.size(), beatWrQ.sum() with (int'(item)), doneCount);
    end
    nCompared++;
    if (cmd_ready !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL busy_idle_after: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    int waitCnt;
    readyMode = 0;
    clearMon();
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = ADDR'(40); cmd_len = (ADDR+1)'(8);
    tick();
    cmd_valid = 1'b0;
    waitCnt = 0;
    while (beatAddrQ.size() < 2 && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    rst = 1'b1;
    tick();
    nCompared++;
    if (mem_valid !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid: valid %b done %b ready %b required 0,0,0", mem_valid, done, cmd_ready);
    end
    tick();
    rst = 1'b0;
    initRef();
    tick();
    nCompared++;
    if (cmd_ready !== 1'b1 || doneCount != 0) begin
      nMismatched++;
      $display("[TB] FAIL reset_mid_release: ready %b done %0d required 1,0", cmd_ready, doneCount);
    end
  endtask

  task automatic checkOutput(input bit wr, input int addr, input int len);
    int a;
    nCompared++;
    if (beatAddrQ.size() != len) begin
      nMismatched++;
      $display("[TB] FAIL rand_beats: got %0d required %0d", beatAddrQ.size(), len);
    end
    for (int i = 0; i < len && i < beatAddrQ.size(); i++) begin
      a = (addr + i) % DEPTH;
      nCompared++;
      if (beatAddrQ[i] != a) begin
        nMismatched++;
        $display("[TB] FAIL rand_addr%0d: got %0d required %0d", i, beatAddrQ[i], a);
      end
      if (wr) begin
        nCompared++;
        if (memArr[a] !== refMem[a]) begin
          nMismatched++;
          $display("[TB] FAIL rand_wmem%0d: got %0h required %0h", a, memArr[a], refMem[a]);
        end
      end else begin
        nCompared++;
        if (i >= rdQ.size() || rdQ[i] !== refMem[a]) begin
          nMismatched++;
          $display("[TB] FAIL rand_rdata%0d: got %0h required %0h", i, (i < rdQ.size()) ? rdQ[i] : '0, refMem[a]);
        end
      end
    end
  endtask

  task automatic test_random();
    bit wr;
    int addr, len;
    readyMode = 1;
    for (int n = 0; n < 14; n++) begin
      wr   = (n < 13) ? bit'($urandom_range(0, 1)) : 1'b0;
      addr = (n % 4 == 3) ? $urandom_range(240, 255) : $urandom_range(0, 255);
      len  = (n == 13) ? DEPTH : $urandom_range(1, 24);
      for (int i = 0; i < len; i++) wrWords[i] = WIDTH'($urandom);
      applyStimulus(wr, addr, len, 1'b0);
      if (wr) for (int i = 0; i < len; i++) refMem[(addr + i) % DEPTH] = wrWords[i];
      checkOutput(wr, addr, len);
    end
    nCompared++;
    if (err !== 1'b0) begin
      nMismatched++;
      $display("[TB] FAIL err_idle: got %b required 0", err);
    end
  endtask

`ifdef MBC_TIMEOUT_EN
  task automatic test_timeout();
    readyMode = 2;
    applyStimulus(1'b0, 5, 4, 1'b0);
    nCompared++;
    if (validSeen != TIMEOUT || beatAddrQ.size() != 0 || doneCount != 1) begin
      nMismatched++;
      $display("[TB] FAIL timeout_abort: valid %0d beats %0d done %0d required %0d,0,1", validSeen, beatAddrQ.size(), doneCount, TIMEOUT);
    end
    nCompared++;
    if (err !== 1'b1) begin
      nMismatched++;
      $display("[TB] FAIL timeout_err: got %b required 1", err);
    end
    readyMode = 0;
    applyStimulus(1'b0, 5, 1, 1'b0);
    nCompared++;
    if (err !== 1'b0 || rdQ.size() != 1 || rdQ[0] !== refMem[5]) begin
      nMismatched++;
      $display("[TB] FAIL timeout_clear: err %b words %0d required 0 and 1", err, rdQ.size());
    end
  endtask
`endif

  initial begin
    test_reset();
    test_read_basic();
    test_write();
    test_wrap();
    test_len_zero_busy();
    test_reset_mid();
    test_random();
`ifdef MBC_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
